// File: rtl/sdram_arbiter.sv
// Purpose: round-robin arbiter that serialises two masters' single-word accesses onto the SDRAM controller.
// Latency: grant in IDLE, sd_start in the next cycle, done one cycle after the controller finishes.
// Backpressure: a_req/b_req are held by the masters until done; no grant while controller busy or uninitialised.
// Ports: clk/reset; port A and port B (req, we, addr, d in; q, done out);
//        controller command side sd_start/sd_we/sd_addr/sd_d out, sd_busy/sd_q_ready/sd_q/sd_initDone in.
module sdram_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_d,
  output logic [DATA_W-1:0] a_q,
  output logic              a_done,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_d,
  output logic [DATA_W-1:0] b_q,
  output logic              b_done,
  output logic              sd_start,
  output logic              sd_we,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [DATA_W-1:0] sd_d,
  input  logic              sd_busy,
  input  logic              sd_q_ready,
  input  logic [DATA_W-1:0] sd_q,
  input  logic              sd_initDone
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                gnt_b_q, gnt_b_d;      // 1: port B owns the current access
  logic                last_b_q, last_b_d;    // 1: port B was granted most recently
  logic                got_q_q, got_q_d;      // read data already captured for this access
  logic                sd_start_q, sd_start_d;
  logic                sd_we_q, sd_we_d;
  logic [ADDR_W-1:0]   sd_addr_q, sd_addr_d;
  logic [DATA_W-1:0]   sd_d_q, sd_d_d;
  logic [DATA_W-1:0]   a_q_q, a_q_d;
  logic [DATA_W-1:0]   b_q_q, b_q_d;
  logic                a_done_q, a_done_d;
  logic                b_done_q, b_done_d;
  logic                pick_b;

  always_comb begin
    state_d    = state_q;
    gnt_b_d    = gnt_b_q;
    last_b_d   = last_b_q;
    got_q_d    = got_q_q;
    sd_start_d = 1'b0;
    sd_we_d    = sd_we_q;
    sd_addr_d  = sd_addr_q;
    sd_d_d     = sd_d_q;
    a_q_d      = a_q_q;
    b_q_d      = b_q_q;
    a_done_d   = 1'b0;
    b_done_d   = 1'b0;
    // B wins when it is the only requester, or on a tie when A went last.
    pick_b     = b_req && (!a_req || !last_b_q);

    case (state_q)
      IDLE: begin
        if (sd_initDone && !sd_busy && (a_req || b_req)) begin
          gnt_b_d    = pick_b;
          last_b_d   = pick_b;
          got_q_d    = 1'b0;
          sd_we_d    = pick_b ? b_we   : a_we;
          sd_addr_d  = pick_b ? b_addr : a_addr;
          sd_d_d     = pick_b ? b_d    : a_d;
          sd_start_d = 1'b1;   // registered, so the strobe is high during ISSUE
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY, WAIT_DONE: begin
        // Only the first read-data pulse of an access is kept.
        if (!sd_we_q && sd_q_ready && !got_q_q) begin
          got_q_d = 1'b1;
          if (gnt_b_q) b_q_d = sd_q;
          else         a_q_d = sd_q;
        end
        if (state_q == WAIT_BUSY) begin
          if (sd_busy) state_d = WAIT_DONE;
        end else if (!sd_busy && (sd_we_q || got_q_q || sd_q_ready)) begin
          // Data arriving this same cycle is captured on the edge we leave.
          a_done_d = !gnt_b_q;
          b_done_d = gnt_b_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_b_q    <= 1'b0;
      last_b_q   <= 1'b1;   // A wins the first tie
      got_q_q    <= 1'b0;
      sd_start_q <= 1'b0;
      sd_we_q    <= 1'b0;
      sd_addr_q  <= '0;
      sd_d_q     <= '0;
      a_q_q      <= '0;
      b_q_q      <= '0;
      a_done_q   <= 1'b0;
      b_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_b_q    <= gnt_b_d;
      last_b_q   <= last_b_d;
      got_q_q    <= got_q_d;
      sd_start_q <= sd_start_d;
      sd_we_q    <= sd_we_d;
      sd_addr_q  <= sd_addr_d;
      sd_d_q     <= sd_d_d;
      a_q_q      <= a_q_d;
      b_q_q      <= b_q_d;
      a_done_q   <= a_done_d;
      b_done_q   <= b_done_d;
    end
  end

  assign sd_start = sd_start_q;
  assign sd_we    = sd_we_q;
  assign sd_addr  = sd_addr_q;
  assign sd_d     = sd_d_q;
  assign a_q      = a_q_q;
  assign b_q      = b_q_q;
  assign a_done   = a_done_q;
  assign b_done   = b_done_q;

endmodule
